cla_wide_add_seq: RTL
=====================

// Module: cla_wide_add_seq
// PURPOSE
//  Multi-precision add/subtract sequencer around one 16-bit carry-lookahead adder (CLA16bit).
//  Operands of WORDS x 16 bits are fed LSW first, one slice per cycle.
//  Carry-out of each slice is registered and fed back as carry-in of the next.
//  Sits between the ALU issue logic and the shared 16-bit CLA; gives 64-bit add/sub without a 64-bit adder.
// PARAMETERS
//  WORDS   4   number of 16-bit slices per operand (>=2); operand width N = 16*WORDS
// PORTS
//  clk     in   1    rising-edge clock
//  rst     in   1    synchronous reset, active-high
//  start   in   1    request; sampled only when ready=1
//  sub     in   1    0: a+b, 1: a-b; sampled with start
//  a       in   N    operand A; sampled with start
//  b       in   N    operand B; sampled with start
//  ready   out  1    1 in IDLE and DONE (new start accepted)
//  busy    out  1    1 in RUN
//  done    out  1    one-cycle pulse: result valid
//  sum     out  N    result; held stable from done until next accepted start
//  cout    out  1    final carry-out (sub: 1 = no borrow)
//  ovf     out  1    signed two's-complement overflow
// BEHAVIOUR
//  Reset: state=IDLE; sum=0, cout=0, ovf=0, done=0, busy=0, ready=1; slice index=0, carry reg=0.
//  rst overrides everything, including mid-RUN: operation abandoned, no done pulse, outputs zeroed.
//  FSM states: IDLE, RUN, DONE.
//   IDLE/DONE + start=1 -> RUN: latch a, b_eff = sub ? ~b : b, carry=sub, idx=0, clear sum/cout/ovf.
//   IDLE + start=0 -> IDLE.  DONE + start=0 -> IDLE (done drops; results held).
//   RUN: each cycle CLA gets a_l[idx], b_eff[idx], carry; sum[idx] <= s; carry <= cout_cla; idx++.
//   RUN with idx==WORDS-1 -> DONE: cout <= cout_cla; ovf computed; done=1 in DONE state only.
//  start while busy is ignored (not queued); a, b, sub changes during RUN have no effect.
//  Latency: start sampled at edge k -> done high for exactly the cycle after edge k+WORDS.
//  Throughput: start accepted in DONE cycle -> back-to-back ops, one result per WORDS+1 cycles.
//  Overflow: ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]); uses inverted b for sub.
//  Arithmetic is modulo 2^N; no saturation. cout for sub = NOT borrow.
//  sum, cout, ovf change only on an accepted start (cleared) or in RUN/DONE transitions.
//  idx width = clog2(WORDS); idx never exceeds WORDS-1 (wraps to 0 on accepted start).
//  CLA instance is purely combinational; all state in this block's registers.
// TESTING
//  T1 add: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> done at start+5 cycles, sum=0, cout=1, ovf=0.
//  T2 sub: a=5, b=7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
//  T3 ovf: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0;
//     a=64'h8000_0000_0000_0000, b=1, sub -> sum=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
//  T4 start pulsed with new a/b during RUN -> ignored; result matches first op; one done pulse only.
//  T5 rst asserted at 2nd RUN cycle -> next cycle IDLE, ready=1, sum=0, no done; new op then correct.
//  T6 back-to-back: start held high with new operands in DONE cycle -> second done exactly 5 cycles
//     after first; first sum stable through DONE cycle; random 1000-op compare against a+b / a-b.

Source files
------------

// File: rtl/cla_wide_add_seq_if.sv
// Operand/result bundle between the ALU issue logic (master) and the
// multi-precision add/sub sequencer (slave).
interface cla_wide_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int N = 16 * WORDS;

    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cla_wide_add_seq.sv
// Multi-precision add/subtract: WORDS x 16-bit slices pushed LSW first through one
// shared 16-bit carry-lookahead adder, with the slice carry registered between cycles.
module cla_wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    cla_wide_add_seq_if.slave bus
);
    localparam int IDX_W = $clog2(WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Two-level lookahead: 4-bit groups, group generate/propagate feeding group carries.
    function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
        logic [15:0] g;
        logic [15:0] p;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [16:0] c;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        c     = '0;
        c[0]  = ci;
        c[4]  = gg[0] | (gp[0] & ci);
        c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & ci);
        c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | (&gp & ci);
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 3; k++) begin
                c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
            end
        end
        return {c[16], p ^ c[15:0]};
    endfunction

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   carry_q, carry_d;
    logic [WORDS-1:0][15:0] a_q, a_d;
    logic [WORDS-1:0][15:0] b_q, b_d;
    logic [WORDS-1:0][15:0] sum_q, sum_d;
    logic                   cout_q, cout_d;
    logic                   ovf_q, ovf_d;
    logic [16:0]            cla_res;
    logic                   last_slice;

    assign cla_res    = cla16(a_q[idx_q], b_q[idx_q], carry_q);
    assign last_slice = (idx_q == IDX_W'(WORDS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    // Subtract as a + ~b + 1: the +1 rides in on the first slice carry.
                    state_d = S_RUN;
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[idx_q] = cla_res[15:0];
                carry_d      = cla_res[16];
                if (last_slice) begin
                    state_d = S_DONE;
                    cout_d  = cla_res[16];
                    ovf_d   = (a_q[WORDS-1][15] == b_q[WORDS-1][15])
                            && (cla_res[15] != a_q[WORDS-1][15]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand latches are only read in RUN, which always follows a fresh load.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule
